// File: rtl/debug_port_if.sv
// Debug controller signal bundle: UART byte stream plus the single-word debug bus.
// master = debug controller side, slave = UART/bus-interface side.
interface debug_port_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        stopped;
    logic        debug_stop;
    logic        debug_debug;
    logic        debug_rw;
    logic [15:0] debug_addr;
    logic [15:0] debug_dout;
    logic [15:0] debug_din;
    logic        debug_rd;
    logic        debug_wr;

    modport master (
        input  rx_data, rx_valid, tx_ready, stopped, debug_din, debug_rd, debug_wr,
        output tx_data, tx_valid, debug_stop, debug_debug, debug_rw, debug_addr, debug_dout
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, stopped, debug_din, debug_rd, debug_wr,
        input  tx_data, tx_valid, debug_stop, debug_debug, debug_rw, debug_addr, debug_dout
    );
endinterface

// File: rtl/debug_port.sv
// Host debug controller: parses UART commands, halts/resumes the CPU and performs
// single-word debug reads/writes while the CPU is stopped.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command byte
// ADDR_HI | waiting for address bits [15:8]
// ADDR_LO | waiting for address bits [7:0]
// DATA_HI | write only: waiting for data bits [15:8]
// DATA_LO | write only: waiting for data bits [7:0]
// BUS     | debug access outstanding, waiting for DEBUG_RD / DEBUG_WR
// TX_HI   | sending read data bits [15:8]
// TX_LO   | sending read data bits [7:0]
// TX_ONE  | sending a single response byte
module debug_port (
    input  logic         clk,
    input  logic         rst,
    debug_port_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, BUS, TX_HI, TX_LO, TX_ONE
    } state_t;

    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] CMD_S   = 8'h53;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_UNK = 8'h3F;
    localparam logic [7:0] RSP_RUN = 8'h21;

    state_t      state_q,      state_nxt;
    logic [7:0]  tx_data_q,    tx_data_nxt;
    logic        tx_valid_q,   tx_valid_nxt;
    logic        stop_q,       stop_nxt;
    logic        dbg_q,        dbg_nxt;
    logic        rw_q,         rw_nxt;
    logic [15:0] addr_q,       addr_nxt;
    logic [15:0] dout_q,       dout_nxt;
    logic [15:0] rdata_q,      rdata_nxt;
    logic        op_w_q,       op_w_nxt;
    logic        args_done;
    logic        tx_accept;

    assign tx_accept = tx_valid_q & bus.tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            stop_q     <= 1'b0;
            dbg_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 16'h0000;
            dout_q     <= 16'h0000;
            rdata_q    <= 16'h0000;
            op_w_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_valid_q <= tx_valid_nxt;
            stop_q     <= stop_nxt;
            dbg_q      <= dbg_nxt;
            rw_q       <= rw_nxt;
            addr_q     <= addr_nxt;
            dout_q     <= dout_nxt;
            rdata_q    <= rdata_nxt;
            op_w_q     <= op_w_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        tx_data_nxt  = tx_data_q;
        tx_valid_nxt = tx_valid_q;
        stop_nxt     = stop_q;
        dbg_nxt      = dbg_q;
        rw_nxt       = rw_q;
        addr_nxt     = addr_q;
        dout_nxt     = dout_q;
        rdata_nxt    = rdata_q;
        op_w_nxt     = op_w_q;
        args_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    state_nxt    = TX_ONE;
                    tx_valid_nxt = 1'b1;
                    case (bus.rx_data)
                        CMD_H: begin
                            stop_nxt    = 1'b1;
                            tx_data_nxt = RSP_OK;
                        end
                        CMD_G: begin
                            stop_nxt    = 1'b0;
                            tx_data_nxt = RSP_OK;
                        end
                        CMD_S: tx_data_nxt = {7'b0, bus.stopped};
                        CMD_R, CMD_W: begin
                            op_w_nxt     = (bus.rx_data == CMD_W);
                            state_nxt    = ADDR_HI;
                            tx_valid_nxt = 1'b0;
                        end
                        default: tx_data_nxt = RSP_UNK;
                    endcase
                end
            end
            ADDR_HI: begin
                if (bus.rx_valid) begin
                    addr_nxt[15:8] = bus.rx_data;
                    state_nxt      = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (bus.rx_valid) begin
                    addr_nxt[7:0] = bus.rx_data;
                    if (op_w_q) state_nxt = DATA_HI;
                    else        args_done = 1'b1;
                end
            end
            DATA_HI: begin
                if (bus.rx_valid) begin
                    dout_nxt[15:8] = bus.rx_data;
                    state_nxt      = DATA_LO;
                end
            end
            DATA_LO: begin
                if (bus.rx_valid) begin
                    dout_nxt[7:0] = bus.rx_data;
                    args_done     = 1'b1;
                end
            end
            BUS: begin
                // Strobes of the opposite direction are ignored.
                if (!op_w_q && bus.debug_rd) begin
                    rdata_nxt    = bus.debug_din;
                    dbg_nxt      = 1'b0;
                    tx_data_nxt  = bus.debug_din[15:8];
                    tx_valid_nxt = 1'b1;
                    state_nxt    = TX_HI;
                end else if (op_w_q && bus.debug_wr) begin
                    dbg_nxt      = 1'b0;
                    tx_data_nxt  = RSP_OK;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = TX_ONE;
                end
            end
            TX_HI: begin
                if (tx_accept) begin
                    tx_data_nxt = rdata_q[7:0];
                    state_nxt   = TX_LO;
                end
            end
            TX_LO, TX_ONE: begin
                if (tx_accept) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // STOPPED is only consulted on the last argument byte.
        if (args_done) begin
            tx_valid_nxt = 1'b0;
            if (bus.stopped) begin
                state_nxt = BUS;
                dbg_nxt   = 1'b1;
                rw_nxt    = op_w_q;
            end else begin
                state_nxt    = TX_ONE;
                tx_data_nxt  = RSP_RUN;
                tx_valid_nxt = 1'b1;
            end
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.debug_stop  = stop_q;
    assign bus.debug_debug = dbg_q;
    assign bus.debug_rw    = rw_q;
    assign bus.debug_addr  = addr_q;
    assign bus.debug_dout  = dout_q;
endmodule

// File: tb/tb_debug_port.sv
// Directed bench for debug_port: expected TX bytes are queued as commands are sent
// and checked when the UART side accepts them; bus-side signals are checked inline.
module tb_debug_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] sb[$];
    logic dbg_seen = 1'b0;

    debug_port_if dif();

    debug_port dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // UART-side monitor: compare each accepted byte against the scoreboard.
    always @(negedge clk) begin
        if (!rst && dif.debug_debug) dbg_seen <= 1'b1;
        if (!rst && dif.tx_valid && dif.tx_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL tx_unexpected observed=%h expected=none", dif.tx_data);
            end
            if (sb.size() > 0) begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                assert (dif.tx_data === exp_b) else begin
                    bad++;
                    $error("FAIL tx_byte observed=%h expected=%h", dif.tx_data, exp_b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        dif.rx_data  = b;
        dif.rx_valid = 1'b1;
        tick();
        dif.rx_valid = 1'b0;
        dif.rx_data  = 8'h00;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !dif.tx_valid) break;
            tick();
        end
        check(tag, {31'(sb.size()), dif.tx_valid}, 32'h0);
    endtask

    initial begin
        dif.rx_data   = 8'h00;
        dif.rx_valid  = 1'b0;
        dif.tx_ready  = 1'b1;
        dif.stopped   = 1'b0;
        dif.debug_din = 16'h0000;
        dif.debug_rd  = 1'b0;
        dif.debug_wr  = 1'b0;

        // Reset state
        #12;
        check("rst_tx_valid", dif.tx_valid, 0);
        check("rst_tx_data", dif.tx_data, 0);
        check("rst_outputs", {dif.debug_stop, dif.debug_debug, dif.debug_rw}, 0);
        check("rst_addr_dout", {dif.debug_addr, dif.debug_dout}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a write command
        send(8'h57);
        send(8'h12);
        check("w_addr_hi", dif.debug_addr, 16'h1200);
        rst = 1'b1;
        #1;
        check("async_rst_addr", dif.debug_addr, 16'h0000);
        check("async_rst_flags", {dif.tx_valid, dif.debug_debug, dif.debug_rw, dif.debug_stop}, 0);
        tick();
        rst = 1'b0;
        tick();
        sb.push_back(8'h00);
        send(8'h53);
        check("s_latency", dif.tx_valid, 1);
        drain("drain_status0");

        // Halt and status
        sb.push_back(8'h4B);
        send(8'h48);
        drain("drain_halt");
        check("halt_stop", dif.debug_stop, 1);
        dif.stopped = 1'b1;
        sb.push_back(8'h01);
        send(8'h53);
        drain("drain_status1");

        // Read with a wrong-direction strobe ignored first
        sb.push_back(8'h33);
        sb.push_back(8'h34);
        send(8'h52);
        send(8'h55);
        check("rd_no_dbg_early", dif.debug_debug, 0);
        send(8'h56);
        check("rd_dbg", dif.debug_debug, 1);
        check("rd_addr", dif.debug_addr, 16'h5556);
        check("rd_rw", dif.debug_rw, 0);
        dif.debug_wr = 1'b1;
        tick();
        dif.debug_wr = 1'b0;
        check("rd_wr_ignored", dif.debug_debug, 1);
        dif.debug_din = 16'h3334;
        dif.debug_rd  = 1'b1;
        tick();
        dif.debug_rd  = 1'b0;
        dif.debug_din = 16'h0000;
        check("rd_dbg_fall", dif.debug_debug, 0);
        check("rd_tx_rise", {dif.tx_valid, dif.tx_data}, {1'b1, 8'h33});
        drain("drain_read");

        // Write
        sb.push_back(8'h4B);
        send(8'h57);
        send(8'h55);
        send(8'h55);
        send(8'h44);
        send(8'h43);
        check("wr_dbg", dif.debug_debug, 1);
        check("wr_rw", dif.debug_rw, 1);
        check("wr_addr_dout", {dif.debug_addr, dif.debug_dout}, {16'h5555, 16'h4443});
        dif.debug_wr = 1'b1;
        tick();
        dif.debug_wr = 1'b0;
        check("wr_dbg_fall", dif.debug_debug, 0);
        check("wr_tx_rise", dif.tx_valid, 1);
        drain("drain_write");
        check("wr_stop_kept", dif.debug_stop, 1);

        // Resume, then access while running; a later stop must not enable it
        sb.push_back(8'h4B);
        send(8'h47);
        drain("drain_go");
        check("go_stop", dif.debug_stop, 0);
        dif.stopped = 1'b0;
        dbg_seen = 1'b0;
        sb.push_back(8'h21);
        send(8'h52);
        send(8'h11);
        send(8'h11);
        dif.stopped = 1'b1;
        check("run_tx", {dif.tx_valid, dif.tx_data}, {1'b1, 8'h21});
        drain("drain_run");
        tick();
        check("run_no_dbg", dbg_seen, 0);
        dif.stopped = 1'b0;

        // Unknown byte with backpressure; a byte arriving meanwhile is discarded
        dif.tx_ready = 1'b0;
        sb.push_back(8'h3F);
        send(8'h00);
        send(8'h48);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {dif.tx_valid, dif.tx_data}, {1'b1, 8'h3F});
            tick();
        end
        dif.tx_ready = 1'b1;
        drain("drain_bp");
        check("bp_discard", dif.debug_stop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
